// File: rtl/hazard_pkg.sv
// Shared types and helpers for the pipeline hazard unit.
package hazard_pkg;

   localparam int unsigned REG_W = 5;

   typedef enum logic [1:0] {
      RUN  = 2'b00,
      WAIT = 2'b01,
      ERR  = 2'b10
   } hz_state_t;

   typedef enum logic [1:0] {
      FWD_RF = 2'b00,
      FWD_W  = 2'b01,
      FWD_M  = 2'b10
   } fwd_sel_t;

   // True when a later stage writes the (non-zero) source register.
   function automatic logic reg_hit(input logic [REG_W-1:0] src,
                                    input logic [REG_W-1:0] dst,
                                    input logic             we);
      return we && (src != '0) && (src == dst);
   endfunction

endpackage

// File: rtl/fwd_sel.sv
// Forwarding source select for one E-stage operand; M result beats W result.
module fwd_sel
   import hazard_pkg::*;
(
   input  logic [REG_W-1:0] i_src,
   input  logic [REG_W-1:0] i_wr_m,
   input  logic             i_we_m,
   input  logic [REG_W-1:0] i_wr_w,
   input  logic             i_we_w,
   output fwd_sel_t         o_sel
);

   always_comb begin
      o_sel = FWD_RF;
      if (reg_hit(i_src, i_wr_m, i_we_m)) begin
         o_sel = FWD_M;
      end else if (reg_hit(i_src, i_wr_w, i_we_w)) begin
         o_sel = FWD_W;
      end
   end

endmodule

// File: rtl/hazard_unit.sv
// Hazard unit: operand forwarding, load-use / branch / dmem-wait stall and flush control,
// dmem wait sequencing with timeout and a saturating stall-cycle counter.
module hazard_unit
   import hazard_pkg::*;
#(
   parameter int unsigned MEM_TIMEOUT = 64,
   parameter int unsigned CNT_W       = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [REG_W-1:0] RsD,
   input  logic [REG_W-1:0] RtD,
   input  logic [REG_W-1:0] RsE,
   input  logic [REG_W-1:0] RtE,
   input  logic [REG_W-1:0] WriteRegE,
   input  logic [REG_W-1:0] WriteRegM,
   input  logic [REG_W-1:0] WriteRegW,
   input  logic             regwriteE,
   input  logic             regwriteM,
   input  logic             regwriteW,
   input  logic             memtoregE,
   input  logic             pcsrcM,
   input  logic             dmem_req,
   input  logic             dmem_ready,
   output logic [1:0]       forwardAE,
   output logic [1:0]       forwardBE,
   output logic             stallF,
   output logic             stallD,
   output logic             stallE,
   output logic             stallM,
   output logic             flushD,
   output logic             flushE,
   output logic             flushM,
   output logic             flushW,
   output logic             mem_err,
   output logic [CNT_W-1:0] stall_cnt
);

   localparam int unsigned WC_W = $clog2(MEM_TIMEOUT) + 1;

   hz_state_t        r_state;
   logic [WC_W-1:0]  r_wait_cnt;
   logic             r_mem_err;
   logic [CNT_W-1:0] r_stall_cnt;

   fwd_sel_t w_fwd_a;
   fwd_sel_t w_fwd_b;
   logic     w_memwait;
   logic     w_lwstall;

   fwd_sel u_fwd_a (
      .i_src  (RsE),
      .i_wr_m (WriteRegM),
      .i_we_m (regwriteM),
      .i_wr_w (WriteRegW),
      .i_we_w (regwriteW),
      .o_sel  (w_fwd_a)
   );

   fwd_sel u_fwd_b (
      .i_src  (RtE),
      .i_wr_m (WriteRegM),
      .i_we_m (regwriteM),
      .i_wr_w (WriteRegW),
      .i_we_w (regwriteW),
      .o_sel  (w_fwd_b)
   );

   assign forwardAE = rst_n ? w_fwd_a : FWD_RF;
   assign forwardBE = rst_n ? w_fwd_b : FWD_RF;

   // ERR keeps the pipeline frozen regardless of the memory handshake.
   assign w_memwait = (dmem_req && !dmem_ready) || (r_state == ERR);
   assign w_lwstall = memtoregE && regwriteE && (RtE != '0) &&
                      ((RtE == RsD) || (RtE == RtD));

   // A load in E always targets RtE, so its destination must match.
   always_comb begin
      if (rst_n && memtoregE && regwriteE) begin
         assert (WriteRegE == RtE);
      end
   end

   // Priority mux: dmem wait, then taken branch, then load-use bubble.
   always_comb begin
      stallF = 1'b0;
      stallD = 1'b0;
      stallE = 1'b0;
      stallM = 1'b0;
      flushD = 1'b0;
      flushE = 1'b0;
      flushM = 1'b0;
      flushW = 1'b0;
      if (!rst_n) begin
         stallF = 1'b0;
      end else if (w_memwait) begin
         stallF = 1'b1;
         stallD = 1'b1;
         stallE = 1'b1;
         stallM = 1'b1;
         flushW = 1'b1;
      end else if (pcsrcM) begin
         flushD = 1'b1;
         flushE = 1'b1;
         flushM = 1'b1;
      end else if (w_lwstall) begin
         stallF = 1'b1;
         stallD = 1'b1;
         flushE = 1'b1;
      end
   end

   // Wait sequencer; the RUN cycle that raises the wait is counted as the first wait cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= RUN;
         r_wait_cnt  <= '0;
         r_mem_err   <= 1'b0;
         r_stall_cnt <= '0;
      end else begin
         if (stallF && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + CNT_W'(1);
         end
         case (r_state)
            RUN: begin
               if (w_memwait) begin
                  r_state    <= WAIT;
                  r_wait_cnt <= WC_W'(1);
               end
            end
            WAIT: begin
               if (dmem_req && !dmem_ready) begin
                  if (r_wait_cnt == WC_W'(MEM_TIMEOUT - 1)) begin
                     r_state   <= ERR;
                     r_mem_err <= 1'b1;
                  end else begin
                     r_wait_cnt <= r_wait_cnt + WC_W'(1);
                  end
               end else begin
                  r_state    <= RUN;
                  r_wait_cnt <= '0;
               end
            end
            ERR: begin
               r_mem_err <= 1'b1;
            end
            default: begin
               r_state    <= RUN;
               r_wait_cnt <= '0;
            end
         endcase
      end
   end

   assign mem_err   = r_mem_err;
   assign stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_hazard_unit.sv
// Directed-vector bench for hazard_unit with a queue-based scoreboard checked at negedge.
module tb_hazard_unit;

   logic        clk;
   logic        rst_n;
   logic [4:0]  RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW;
   logic        regwriteE, regwriteM, regwriteW, memtoregE, pcsrcM, dmem_req, dmem_ready;
   logic [1:0]  forwardAE, forwardBE;
   logic        stallF, stallD, stallE, stallM;
   logic        flushD, flushE, flushM, flushW;
   logic        mem_err;
   logic [15:0] stall_cnt;

   typedef struct {
      int          id;
      logic [1:0]  fa;
      logic [1:0]  fb;
      logic [3:0]  st;
      logic [3:0]  fl;
      logic        err;
      logic [15:0] cnt;
   } exp_t;

   exp_t        exp_q[$];
   int          checks = 0;
   int          errors = 0;
   logic [15:0] exp_cnt = '0;

   hazard_unit #(.MEM_TIMEOUT(64), .CNT_W(16)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .RsD        (RsD),
      .RtD        (RtD),
      .RsE        (RsE),
      .RtE        (RtE),
      .WriteRegE  (WriteRegE),
      .WriteRegM  (WriteRegM),
      .WriteRegW  (WriteRegW),
      .regwriteE  (regwriteE),
      .regwriteM  (regwriteM),
      .regwriteW  (regwriteW),
      .memtoregE  (memtoregE),
      .pcsrcM     (pcsrcM),
      .dmem_req   (dmem_req),
      .dmem_ready (dmem_ready),
      .forwardAE  (forwardAE),
      .forwardBE  (forwardBE),
      .stallF     (stallF),
      .stallD     (stallD),
      .stallE     (stallE),
      .stallM     (stallM),
      .flushD     (flushD),
      .flushE     (flushE),
      .flushM     (flushM),
      .flushW     (flushW),
      .mem_err    (mem_err),
      .stall_cnt  (stall_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic clr();
      RsD = '0; RtD = '0; RsE = '0; RtE = '0;
      WriteRegE = '0; WriteRegM = '0; WriteRegW = '0;
      regwriteE = 1'b0; regwriteM = 1'b0; regwriteW = 1'b0;
      memtoregE = 1'b0; pcsrcM = 1'b0; dmem_req = 1'b0; dmem_ready = 1'b0;
   endtask

   // Queue the expectation for the current input vector, then advance one cycle.
   task automatic step(input int id, input logic [1:0] fa, input logic [1:0] fb,
                       input logic [3:0] st, input logic [3:0] fl, input logic err);
      exp_t e;
      if (!rst_n) exp_cnt = '0;
      e.id = id; e.fa = fa; e.fb = fb; e.st = st; e.fl = fl; e.err = err; e.cnt = exp_cnt;
      exp_q.push_back(e);
      @(posedge clk);
      #1;
      if (!rst_n) exp_cnt = '0;
      else if (st[3] && exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
   endtask

   // Monitor: outputs are combinational, so each queued vector is checked mid-cycle.
   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         exp_t e;
         logic [3:0] g_st, g_fl;
         e = exp_q.pop_front();
         g_st = {stallF, stallD, stallE, stallM};
         g_fl = {flushD, flushE, flushM, flushW};
         checks++;
         if (forwardAE !== e.fa || forwardBE !== e.fb || g_st !== e.st ||
             g_fl !== e.fl || mem_err !== e.err || stall_cnt !== e.cnt) begin
            errors++;
            $display("FAIL vec%0d: got fa=%b fb=%b st=%b fl=%b err=%b cnt=%0d, expected fa=%b fb=%b st=%b fl=%b err=%b cnt=%0d",
                     e.id, forwardAE, forwardBE, g_st, g_fl, mem_err, stall_cnt,
                     e.fa, e.fb, e.st, e.fl, e.err, e.cnt);
         end
      end
   end

   initial begin
      rst_n = 1'b0;
      clr();
      @(posedge clk);
      #1;

      // Outputs gated while in reset even with hazards present
      RsE = 5; WriteRegM = 5; regwriteM = 1; dmem_req = 1;
      step(1, 2'b00, 2'b00, 4'b0000, 4'b0000, 0);
      rst_n = 1'b1; clr();
      step(2, 2'b00, 2'b00, 4'b0000, 4'b0000, 0);

      // Forwarding
      RsE = 5; WriteRegM = 5; regwriteM = 1; WriteRegW = 5; regwriteW = 1;
      step(3, 2'b10, 2'b00, 4'b0000, 4'b0000, 0);
      regwriteM = 0;
      step(4, 2'b01, 2'b00, 4'b0000, 4'b0000, 0);
      RsE = 0; WriteRegM = 0; regwriteM = 1; WriteRegW = 0; regwriteW = 1;
      step(5, 2'b00, 2'b00, 4'b0000, 4'b0000, 0);
      RsE = 3; RtE = 7; WriteRegM = 3; regwriteM = 1; WriteRegW = 7; regwriteW = 1;
      step(6, 2'b10, 2'b01, 4'b0000, 4'b0000, 0);
      RsE = 9; RtE = 9; WriteRegM = 9; regwriteM = 0; WriteRegW = 9; regwriteW = 0;
      step(7, 2'b00, 2'b00, 4'b0000, 4'b0000, 0);

      // Load-use: one bubble then clear
      clr();
      memtoregE = 1; regwriteE = 1; RtE = 8; WriteRegE = 8; RsD = 8;
      step(8, 2'b00, 2'b00, 4'b1100, 4'b0100, 0);
      memtoregE = 0; regwriteE = 0; RtE = 0; WriteRegE = 0;
      step(9, 2'b00, 2'b00, 4'b0000, 4'b0000, 0);
      clr();
      memtoregE = 1; regwriteE = 1; RtE = 4; WriteRegE = 4; RtD = 4;
      step(10, 2'b00, 2'b00, 4'b1100, 4'b0100, 0);
      clr();
      memtoregE = 1; regwriteE = 1;
      step(11, 2'b00, 2'b00, 4'b0000, 4'b0000, 0);

      // Branch beats load-use; counter untouched
      clr();
      memtoregE = 1; regwriteE = 1; RtE = 8; WriteRegE = 8; RsD = 8; pcsrcM = 1;
      step(12, 2'b00, 2'b00, 4'b0000, 4'b1110, 0);
      clr(); pcsrcM = 1;
      step(13, 2'b00, 2'b00, 4'b0000, 4'b1110, 0);

      // Three-cycle dmem wait with a deferred branch and a masked load-use
      clr(); dmem_req = 1;
      step(14, 2'b00, 2'b00, 4'b1111, 4'b0001, 0);
      pcsrcM = 1;
      step(15, 2'b00, 2'b00, 4'b1111, 4'b0001, 0);
      memtoregE = 1; regwriteE = 1; RtE = 6; WriteRegE = 6; RsD = 6;
      step(16, 2'b00, 2'b00, 4'b1111, 4'b0001, 0);
      dmem_ready = 1;
      step(17, 2'b00, 2'b00, 4'b0000, 4'b1110, 0);
      clr();
      step(18, 2'b00, 2'b00, 4'b0000, 4'b0000, 0);
      dmem_req = 1; dmem_ready = 1;
      step(19, 2'b00, 2'b00, 4'b0000, 4'b0000, 0);

      // Timeout: 64 wait cycles without mem_err, then sticky ERR ignoring ready
      clr(); dmem_req = 1;
      for (int i = 0; i < 64; i++) begin
         step(100 + i, 2'b00, 2'b00, 4'b1111, 4'b0001, 0);
      end
      step(200, 2'b00, 2'b00, 4'b1111, 4'b0001, 1);
      dmem_req = 0; dmem_ready = 1;
      step(201, 2'b00, 2'b00, 4'b1111, 4'b0001, 1);

      // Async reset out of ERR
      dmem_req = 1; dmem_ready = 0; rst_n = 1'b0;
      step(202, 2'b00, 2'b00, 4'b0000, 4'b0000, 0);
      rst_n = 1'b1; dmem_req = 0; dmem_ready = 0;
      step(203, 2'b00, 2'b00, 4'b0000, 4'b0000, 0);

      // Async reset in the middle of a wait
      dmem_req = 1;
      step(204, 2'b00, 2'b00, 4'b1111, 4'b0001, 0);
      step(205, 2'b00, 2'b00, 4'b1111, 4'b0001, 0);
      rst_n = 1'b0;
      step(206, 2'b00, 2'b00, 4'b0000, 4'b0000, 0);
      rst_n = 1'b1; dmem_ready = 1;
      step(207, 2'b00, 2'b00, 4'b0000, 4'b0000, 0);
      clr(); RtE = 2; WriteRegM = 2; regwriteM = 1;
      step(208, 2'b00, 2'b10, 4'b0000, 4'b0000, 0);

      for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
      #1;
      if (exp_q.size() > 0) begin
         checks++;
         errors++;
         $display("FAIL drain: %0d expectations left unchecked, required 0", exp_q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
